uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the input byte buffer; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock and all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_data_valid  input  1  byte offered on i_data_byte this cycle.
REQ-006 SHALL have port i_data_byte  input  8  byte to transmit.
REQ-007 SHALL have port o_ready  output  1  buffer not full; a byte is accepted on any edge where i_data_valid && o_ready.
REQ-008 SHALL have port o_tx  output  1  serial line, idle high, driven directly from a register.
REQ-009 SHALL have port o_busy  output  1  high while the FSM is outside IDLE.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (1), for 11*CLKS_PER_BIT cycles per frame.
REQ-012 Every bit SHALL be held on o_tx for exactly CLKS_PER_BIT cycles, timed by a 16-bit counter that runs 0..CLKS_PER_BIT-1 and then wraps to 0.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; any unused encoding SHALL return to IDLE on the next edge with o_tx=1.
REQ-014 IDLE: o_tx=1; if the buffer is non-empty, pop the head byte into a shift register, latch the parity, clear the counter and bit index, and go to START.
REQ-015 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-016 DATA: o_tx=data[index]; after CLKS_PER_BIT cycles, index increments; after index 7 completes, go to PARITY.
REQ-017 PARITY: o_tx=parity for CLKS_PER_BIT cycles, then go to STOP.
REQ-018 STOP: o_tx=1 for CLKS_PER_BIT cycles; on the last cycle, assert o_done for exactly one cycle.
REQ-019 At the end of STOP, if the buffer is non-empty, the FSM SHALL pop and enter START directly, so the next start bit follows the stop bit with zero idle cycles; otherwise it SHALL go to IDLE.
REQ-020 Latency: a byte accepted at edge k into an empty buffer while in IDLE SHALL drive o_tx low from edge k+2.
REQ-021 o_ready SHALL equal !full, derived combinationally from the registered buffer state. When full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-022 When not full, a simultaneous push and pop SHALL both take effect and leave the occupancy unchanged.
REQ-023 Buffer read and write pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked so that full and empty are distinguishable at pointer equality.
REQ-024 The byte being transmitted SHALL be held in the shift register, so changes to i_data_byte or the buffer contents never corrupt an in-flight frame.
REQ-025 Bytes SHALL be transmitted in acceptance order, none dropped or duplicated while o_ready protocol is honoured.

Reset
REQ-026 While reset is high at a clock edge: o_tx=1, o_busy=0, o_done=0, o_ready=1, state=IDLE, and the counter, index, pointers and occupancy are all 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, forcing o_tx high on the next edge and discarding all buffered bytes.
REQ-028 A byte presented on an edge where reset is high SHALL NOT be accepted.

Verification
REQ-029 CLKS_PER_BIT=10: push 0xA5 once -> o_tx low from edge k+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1; o_done pulses once, 110 cycles after the frame start.
REQ-030 Push 0x01 -> parity bit=1. Push 0x00 -> parity bit=0. Loopback into the existing receiver -> byte matched and error=0 in both cases.
REQ-031 Push 6 bytes back-to-back (0x11..0x16) with FIFO_DEPTH=4 -> o_ready drops once the buffer is full; all 6 bytes are transmitted in order with no idle gap; 6 o_done pulses.
REQ-032 Buffer full with a push and a frame-end pop in the same cycle -> push refused, occupancy becomes DEPTH-1, o_ready rises the next cycle.
REQ-033 Assert reset for 1 cycle during the DATA bit of index 3 of 0x5A with 2 bytes queued -> o_tx=1 and o_busy=0 the next cycle; nothing further is transmitted; o_ready=1.
REQ-034 Hold i_data_valid=0 for 500 cycles after reset -> o_tx stays 1, o_busy stays 0, and o_done never pulses.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8E1 UART transmitter with a small input byte buffer.
// Frames go out back to back while bytes are queued; o_tx and o_done are registered.

module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_data_valid,
  input  logic [7:0] i_data_byte,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        parity;
  logic        cnt_last;
  logic        tx_nxt, done_nxt;
  logic        push, pop;
  logic [7:0]  head;
  logic        full, empty;

  assign o_ready  = !full;
  assign push     = i_data_valid && !full;
  assign cnt_last = (cnt == CNT_LAST);
  // Pop in IDLE, or at the end of STOP so the next start bit follows with no gap.
  assign pop      = !empty && ((state == IDLE) || (state == STOP && cnt_last));
  assign o_busy   = (state != IDLE);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (i_data_byte),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   if (cnt_last) state_nxt = DATA;
      DATA:    if (cnt_last && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY:  if (cnt_last) state_nxt = STOP;
      STOP:    if (cnt_last) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = 1'b1;
    done_nxt = 1'b0;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[0];
      PARITY:  tx_nxt = parity;
      STOP:    done_nxt = cnt_last;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Registered line driver: o_tx lags the FSM by one cycle, glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tx   <= 1'b1;
      o_done <= 1'b0;
    end else begin
      o_tx   <= tx_nxt;
      o_done <= done_nxt;
    end
  end

  // The in-flight byte lives only in shreg, isolated from the buffer and input.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
    end else if (pop) begin
      shreg   <= head;
      parity  <= ^head;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state inside {START, DATA, PARITY, STOP}) begin
      cnt <= cnt_last ? 16'd0 : cnt + 16'd1;
      if (state == DATA && cnt_last) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end else begin
      cnt     <= '0;
      bit_idx <= '0;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized bench for uart_transmitter against a frame-level reference model.
module tb_uart_transmitter;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_data_valid;
  logic [7:0] i_data_byte;
  logic       o_ready, o_tx, o_busy, o_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_data_valid (i_data_valid),
    .i_data_byte  (i_data_byte),
    .o_ready      (o_ready),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Model: queue of accepted bytes plus the frame in flight and its cycle offset.
  logic [7:0] q[$];
  logic       m_busy = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_tx   = 1'b1;
  logic       m_done = 1'b0;
  int         done_seen = 0;
  logic       ready_low_seen = 1'b0;

  function automatic logic frame_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic do_push, do_pop;
    if (reset) begin
      q.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_tx   = 1'b1;
      m_done = 1'b0;
      return;
    end
    do_push = i_data_valid && (q.size() < DEPTH);
    m_tx    = m_busy ? frame_bit(m_byte, m_t / CPB) : 1'b1;
    m_done  = m_busy && (m_t == FRAME - 1);
    do_pop  = (!m_busy || m_t == FRAME - 1) && (q.size() > 0);
    if (m_busy) begin
      m_t++;
      if (m_t == FRAME) m_busy = 1'b0;
    end
    if (do_pop) begin
      m_byte = q.pop_front();
      m_t    = 0;
      m_busy = 1'b1;
    end
    if (do_push) q.push_back(i_data_byte);
  endtask

  task automatic cycle(logic r, logic v, logic [7:0] b);
    reset        = r;
    i_data_valid = v;
    i_data_byte  = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tx",    32'(o_tx),    32'(m_tx));
    chk("busy",  32'(o_busy),  32'(m_busy));
    chk("ready", 32'(o_ready), (q.size() < DEPTH) ? 1 : 0);
    chk("done",  32'(o_done),  32'(m_done));
    if (o_done)   done_seen++;
    if (!o_ready) ready_low_seen = 1'b1;
  endtask

  initial begin
    int idx;
    int d0;
    int bound;
    logic acc;

    // Reset with a byte offered: must not be accepted.
    repeat (3) cycle(1'b1, 1'b1, 8'h77);

    // Long idle.
    d0 = done_seen;
    repeat (500) cycle(1'b0, 1'b0, 8'h00);
    chk("idle_done", done_seen - d0, 0);

    // Single frames, including the parity corner bytes.
    cycle(1'b0, 1'b1, 8'hA5);
    repeat (125) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h01);
    repeat (125) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    d0 = done_seen;
    repeat (125) cycle(1'b0, 1'b0, 8'h00);
    chk("single_done", done_seen - d0, 1);

    // Six bytes back to back through a four-entry buffer.
    idx = 0;
    d0  = done_seen;
    ready_low_seen = 1'b0;
    repeat (800) begin
      acc = o_ready && (idx < 6);
      cycle(1'b0, idx < 6, 8'(8'h11 + idx));
      if (acc) idx++;
    end
    chk("b2b_sent",      idx, 6);
    chk("b2b_done",      done_seen - d0, 6);
    chk("b2b_ready_low", 32'(ready_low_seen), 1);

    // Reset during data bit 3 of 0x5A with two bytes queued behind it.
    cycle(1'b0, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 8'h33);
    cycle(1'b0, 1'b1, 8'h44);
    bound = 0;
    while (!(m_busy && m_byte == 8'h5A && (m_t / CPB) == 4) && bound < 200) begin
      cycle(1'b0, 1'b0, 8'h00);
      bound++;
    end
    chk("rst_reach_bit3", (bound < 200) ? 1 : 0, 1);
    cycle(1'b1, 1'b0, 8'h00);
    chk("rst_tx",    32'(o_tx),    1);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_ready", 32'(o_ready), 1);
    d0 = done_seen;
    repeat (300) cycle(1'b0, 1'b0, 8'h00);
    chk("rst_nothing_sent", done_seen - d0, 0);

    // Random traffic with bursty valid and rare resets.
    repeat (6000) begin
      cycle(($urandom_range(0, 999) == 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom));
    end
    repeat (600) cycle(1'b0, 1'b0, 8'h00);
    chk("drain_busy", 32'(o_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
